// File: rtl/usb_nrzi_rx_decoder_pkg.sv
// usb_rx_pkg: line-state and EOP FSM encodings shared by the NRZI receive decoder.
package usb_rx_pkg;
  typedef enum logic [1:0] {LS_J, LS_K, LS_SE0} line_state_e;
  typedef enum logic [1:0] {RX, SE0_1, SE0_2, EOP_J} rx_state_e;
endpackage

// File: rtl/usb_nrzi_rx_decoder_line_state.sv
// usb_line_state: D+/D- line-state decode and the previous J/K state register.
module usb_line_state
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        d_plus_i,
  input  logic        d_minus_i,
  input  logic        shift_enable_i,
  output line_state_e ls_o,
  output line_state_e prev_ls_o
);
  line_state_e prev_q, prev_d;
  assign ls_o = (d_plus_i ^ d_minus_i) ? (d_plus_i ? LS_J : LS_K) : LS_SE0;
  assign prev_d = (shift_enable_i && ls_o != LS_SE0) ? ls_o : prev_q;
  assign prev_ls_o = prev_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) prev_q <= LS_J;
    else prev_q <= prev_d;
endmodule

// File: rtl/usb_nrzi_rx_decoder.sv
// usb_nrzi_rx_decoder: NRZI decode, bit unstuffing, EOP detection and LSB-first deserialisation.
// Define USB_RX_STUFF_CHECK_EN to flag stuff-bit violations on stuff_err.
module usb_nrzi_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = 6,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_plus,
  input  logic              d_minus,
  input  logic              shift_enable,
  input  logic              rcving,
  output logic              d_orig,
  output logic              bit_valid,
  output logic [WORD_W-1:0] rx_word,
  output logic              word_valid,
  output logic              eop,
  output logic              stuff_err
);
`ifdef USB_RX_STUFF_CHECK_EN
  localparam bit STUFF_CHK = 1'b1;
`else
  localparam bit STUFF_CHK = 1'b0;
`endif
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int BW = $clog2(WORD_W);
  line_state_e ls, prev_ls;
  rx_state_e state_q, state_d, st;
  logic [OW-1:0] ones_q, ones_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d, rx_word_q, rx_word_d;
  logic d_orig_q, d_orig_d, bit_valid_q, bit_valid_d, word_valid_q, word_valid_d;
  logic stuff_err_q, stuff_err_d, dec;
  usb_line_state u_line (
    .clk            (clk),
    .n_rst          (n_rst),
    .d_plus_i       (d_plus),
    .d_minus_i      (d_minus),
    .shift_enable_i (shift_enable),
    .ls_o           (ls),
    .prev_ls_o      (prev_ls)
  );
  always_comb begin
    st = (state_q == EOP_J) ? RX : state_q;
    state_d = st;
    ones_d = ones_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    rx_word_d = rx_word_q;
    d_orig_d = d_orig_q;
    bit_valid_d = 1'b0;
    word_valid_d = 1'b0;
    stuff_err_d = 1'b0;
    dec = (ls == prev_ls);
    if (shift_enable) begin
      if (ls == LS_SE0) begin
        state_d = (st == RX) ? SE0_1 : SE0_2;
      end else if (st == SE0_2) begin
        state_d = (ls == LS_J) ? EOP_J : RX;
        stuff_err_d = STUFF_CHK && ls == LS_K;
        ones_d = (ls == LS_J) ? '0 : ones_q;
        bit_cnt_d = (ls == LS_J) ? '0 : bit_cnt_q;
      end else if (st == SE0_1) begin
        state_d = RX;
      end else begin
        d_orig_d = dec;
        if (ones_q == OW'(STUFF_LEN)) begin
          // stuff bit is always dropped; a 1 here starts a new run of ones
          stuff_err_d = STUFF_CHK && dec;
          ones_d = (STUFF_CHK && dec) ? OW'(1) : '0;
        end else begin
          ones_d = dec ? ones_q + OW'(1) : '0;
          bit_valid_d = 1'b1;
          shift_d = {dec, shift_q[WORD_W-1:1]};
          word_valid_d = (bit_cnt_q == BW'(WORD_W - 1));
          bit_cnt_d = word_valid_d ? '0 : bit_cnt_q + BW'(1);
          rx_word_d = word_valid_d ? shift_d : rx_word_q;
        end
      end
    end
    if (!rcving) begin
      state_d = (state_d == EOP_J) ? EOP_J : RX;
      ones_d = '0;
      bit_cnt_d = '0;
      shift_d = shift_q;
      rx_word_d = rx_word_q;
      d_orig_d = d_orig_q;
      bit_valid_d = 1'b0;
      word_valid_d = 1'b0;
      stuff_err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= RX;
      ones_q <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      rx_word_q <= '0;
      d_orig_q <= 1'b1;
      bit_valid_q <= 1'b0;
      word_valid_q <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q <= ones_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      rx_word_q <= rx_word_d;
      d_orig_q <= d_orig_d;
      bit_valid_q <= bit_valid_d;
      word_valid_q <= word_valid_d;
      stuff_err_q <= stuff_err_d;
    end
  assign d_orig = d_orig_q;
  assign bit_valid = bit_valid_q;
  assign rx_word = rx_word_q;
  assign word_valid = word_valid_q;
  assign eop = (state_q == EOP_J);
  assign stuff_err = stuff_err_q;
endmodule

// File: tb/tb_usb_nrzi_rx_decoder.sv
// tb_usb_nrzi_rx_decoder: table vectors, directed corner sequences and randomized line traffic vs a reference model.
module tb_usb_nrzi_rx_decoder;
  localparam int W = 8;
  localparam int SL = 6;
`ifdef USB_RX_STUFF_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, n_rst = 1'b0, d_plus = 1'b1, d_minus = 1'b0, shift_enable = 1'b0, rcving = 1'b1;
  logic d_orig, bit_valid, word_valid, eop, stuff_err;
  logic [W-1:0] rx_word;
  int passed = 0, total = 0;
  int cnt_bv, cnt_wv, cnt_eop, cnt_se;
  logic [W-1:0] got_words[$];
  int m_prev, m_run, m_ones;
  bit m_q[$];
  logic [W-1:0] m_word;
  bit e_bv, e_dor, e_wv, e_eop, e_se;
  int enc_line, enc_ones;
  typedef struct {
    int ls;
    bit bv;
    bit dor;
    bit wv;
    bit ep;
    logic [W-1:0] word;
  } vec_t;
  vec_t tbl[11];

  usb_nrzi_rx_decoder #(.STUFF_LEN(SL), .WORD_W(W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .shift_enable (shift_enable),
    .rcving       (rcving),
    .d_orig       (d_orig),
    .bit_valid    (bit_valid),
    .rx_word      (rx_word),
    .word_valid   (word_valid),
    .eop          (eop),
    .stuff_err    (stuff_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, a, e, $time);
  endtask

  // Reference model: decodes one line sample (0=J 1=K 2=SE0 3=SE1) from the spec's rules.
  task automatic m_step(input int ls, input bit rcv);
    bit dec;
    logic [W-1:0] old_word;
    old_word = m_word;
    e_bv = 0; e_dor = 0; e_wv = 0; e_eop = 0; e_se = 0;
    if (ls >= 2) m_run++;
    else begin
      dec = (ls == m_prev);
      if (m_run >= 2) begin
        if (ls == 0) begin e_eop = 1; m_ones = 0; m_q.delete(); end
        else e_se = CHK;
      end else if (m_run == 0) begin
        if (m_ones == SL) begin
          e_se = CHK && dec;
          m_ones = (CHK && dec) ? 1 : 0;
        end else begin
          m_ones = dec ? m_ones + 1 : 0;
          e_bv = 1; e_dor = dec;
          m_q.push_back(dec);
          if (m_q.size() == W) begin
            for (int i = 0; i < W; i++) m_word[i] = m_q[i];
            e_wv = 1;
            m_q.delete();
          end
        end
      end
      m_prev = ls;
      m_run = 0;
    end
    if (!rcv) begin
      m_run = 0; m_ones = 0; m_q.delete();
      e_bv = 0; e_wv = 0; e_se = 0; m_word = old_word;
    end
  endtask

  task automatic drive(input int ls);
    @(negedge clk);
    d_plus = (ls == 0 || ls == 3);
    d_minus = (ls == 1 || ls == 3);
    shift_enable = 1'b1;
    @(negedge clk);
    shift_enable = 1'b0;
  endtask

  task automatic sample(input int ls);
    m_step(ls, rcving);
    drive(ls);
    chk("bit_valid", bit_valid, e_bv);
    chk("word_valid", word_valid, e_wv);
    chk("eop", eop, e_eop);
    chk("stuff_err", stuff_err, e_se);
    chk("rx_word", rx_word, m_word);
    if (e_bv) chk("d_orig", d_orig, e_dor);
    if (bit_valid) cnt_bv++;
    if (word_valid) begin cnt_wv++; got_words.push_back(rx_word); end
    if (eop) cnt_eop++;
    if (stuff_err) cnt_se++;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_pulses", {bit_valid, word_valid, eop, stuff_err}, 4'b0);
      chk("idle_rx_word", rx_word, m_word);
    end
  endtask

  task automatic clr_cnt();
    cnt_bv = 0; cnt_wv = 0; cnt_eop = 0; cnt_se = 0;
    got_words.delete();
  endtask

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_ones = 0; m_q.delete(); m_word = '0;
    enc_line = 0; enc_ones = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    d_plus = 1'b1; d_minus = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic enc_bit(input bit b);
    if (b) begin
      sample(enc_line);
      enc_ones++;
      if (enc_ones == SL) begin enc_line ^= 1; sample(enc_line); enc_ones = 0; end
    end else begin
      enc_line ^= 1; sample(enc_line); enc_ones = 0;
    end
  endtask

  task automatic enc_bits(input logic [W-1:0] b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) enc_bit(b[i]);
  endtask

  task automatic eop_seq();
    sample(2); sample(2); sample(0);
    enc_line = 0; enc_ones = 0;
  endtask

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 0, 8'h00};
    tbl[1]  = '{0, 1, 0, 0, 0, 8'h00};
    tbl[2]  = '{1, 1, 0, 0, 0, 8'h00};
    tbl[3]  = '{0, 1, 0, 0, 0, 8'h00};
    tbl[4]  = '{1, 1, 0, 0, 0, 8'h00};
    tbl[5]  = '{0, 1, 0, 0, 0, 8'h00};
    tbl[6]  = '{1, 1, 0, 0, 0, 8'h00};
    tbl[7]  = '{1, 1, 1, 1, 0, 8'h80};
    tbl[8]  = '{2, 0, 0, 0, 0, 8'h80};
    tbl[9]  = '{2, 0, 0, 0, 0, 8'h80};
    tbl[10] = '{0, 0, 0, 0, 1, 8'h80};
    clr_cnt();
    do_reset();
    @(negedge clk);
    chk("rst_d_orig", d_orig, 1'b1);
    chk("rst_rx_word", rx_word, '0);
    chk("rst_pulses", {bit_valid, word_valid, eop, stuff_err}, 4'b0);

    // SYNC pattern followed by EOP, straight from the table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].ls);
      chk($sformatf("tbl%0d_bit_valid", i), bit_valid, tbl[i].bv);
      if (tbl[i].bv) chk($sformatf("tbl%0d_d_orig", i), d_orig, tbl[i].dor);
      chk($sformatf("tbl%0d_word_valid", i), word_valid, tbl[i].wv);
      chk($sformatf("tbl%0d_eop", i), eop, tbl[i].ep);
      chk($sformatf("tbl%0d_rx_word", i), rx_word, tbl[i].word);
      chk($sformatf("tbl%0d_stuff_err", i), stuff_err, 1'b0);
    end

    // 0xFF then 0x00 with one stuffed zero
    do_reset();
    clr_cnt();
    enc_bits(8'hFF, 0, 7);
    enc_bits(8'h00, 0, 7);
    chk("ff00_bit_valid_cnt", cnt_bv, 16);
    chk("ff00_word_cnt", got_words.size(), 2);
    if (got_words.size() == 2) begin
      chk("ff00_word0", got_words[0], 8'hFF);
      chk("ff00_word1", got_words[1], 8'h00);
    end
    chk("ff00_stuff_err_cnt", cnt_se, 0);
    eop_seq();
    gap(2);

    // seven non-transitions: the seventh is a bad stuff bit
    do_reset();
    clr_cnt();
    for (int i = 0; i < 6; i++) sample(0);
    chk("stuff6_err_cnt", cnt_se, 0);
    sample(0);
    chk("stuff7_err_cnt", cnt_se, CHK ? 1 : 0);
    chk("stuff7_bit_valid_cnt", cnt_bv, 6);
    eop_seq();

    // EOP after three bits, then a full packet
    do_reset();
    clr_cnt();
    enc_bits(8'h05, 0, 2);
    eop_seq();
    chk("eop_cnt", cnt_eop, 1);
    chk("eop_word_cnt", cnt_wv, 0);
    clr_cnt();
    enc_bits(8'hA5, 0, 7);
    chk("post_eop_word_cnt", got_words.size(), 1);
    if (got_words.size() == 1) chk("post_eop_word", got_words[0], 8'hA5);
    gap(2);

    // single-sample SE0 glitch mid-word
    clr_cnt();
    enc_bits(8'h3C, 0, 3);
    sample(2);
    sample(enc_line);
    enc_bits(8'h3C, 4, 7);
    chk("glitch_eop_cnt", cnt_eop, 0);
    chk("glitch_bit_valid_cnt", cnt_bv, 8);
    chk("glitch_word_cnt", got_words.size(), 1);
    if (got_words.size() == 1) chk("glitch_word", got_words[0], 8'h3C);

    // asynchronous reset between bits 4 and 5
    enc_bits(8'h96, 0, 3);
    chk("pre_rst_d_orig", d_orig, 1'b0);
    chk("pre_rst_rx_word", rx_word, 8'h3C);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_d_orig", d_orig, 1'b1);
    chk("async_rst_rx_word", rx_word, '0);
    chk("async_rst_pulses", {bit_valid, word_valid, eop, stuff_err}, 4'b0);
    model_reset();
    d_plus = 1'b1; d_minus = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    clr_cnt();
    enc_bits(8'h96, 0, 7);
    chk("post_rst_bit_valid_cnt", cnt_bv, 8);
    chk("post_rst_word_cnt", got_words.size(), 1);
    if (got_words.size() == 1) chk("post_rst_word", got_words[0], 8'h96);
    eop_seq();

    // randomized line traffic against the model
    for (int i = 0; i < 700; i++) begin
      int r, n, ls;
      r = $urandom_range(99);
      if (r < 5) gap($urandom_range(1, 3));
      else if (r < 12) begin
        ls = $urandom_range(1);
        n = $urandom_range(5, 9);
        for (int k = 0; k < n; k++) sample(ls);
      end else if (r < 15) begin
        rcving = 1'b0;
        sample($urandom_range(3));
        rcving = 1'b1;
      end else if (r < 25) begin
        enc_line = m_prev;
        enc_ones = 0;
        enc_bits(W'($urandom), 0, W - 1);
      end else begin
        n = $urandom_range(99);
        ls = (n < 42) ? 0 : (n < 84) ? 1 : (n < 94) ? 2 : 3;
        sample(ls);
      end
    end
    eop_seq();
    gap(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/usb_nrzi_rx_decoder.md
# usb_nrzi_rx_decoder

Parametrised USB receive decoder. Samples the differential pair once per bit strobe and NRZI-decodes the bit stream. Removes stuffed bits, detects bit-stuff violations and end-of-packet, and deserialises the result into LSB-first words. It sits between the line synchroniser / bit-edge detector and the receive control FSM, which consumes `word_valid`, `eop` and `stuff_err`.

## Interface
Parameters:
- `STUFF_LEN`, 6: consecutive decoded 1s after which the next bit is a stuffed 0.
- `WORD_W`, 8: deserialised word width; range 2..32.

Ports:
- `clk`  in  1: system clock.
- `n_rst`  in  1: asynchronous, active-low reset.
- `d_plus`  in  1: D+ line, already synchronised to `clk`.
- `d_minus`  in  1: D- line, already synchronised to `clk`.
- `shift_enable`  in  1: one-cycle strobe per bit time; the line is sampled only in that cycle.
- `rcving`  in  1: packet in progress. When low, the block idles and clears the bit and word counters.
- `d_orig`  out  1: decoded bit (registered).
- `bit_valid`  out  1: one-cycle pulse; `d_orig` is a real, non-stuffed data bit.
- `rx_word`  out  `WORD_W`: last completed word, LSB = first received bit.
- `word_valid`  out  1: one-cycle pulse; `rx_word` was just updated.
- `eop`  out  1: one-cycle pulse on end-of-packet.
- `stuff_err`  out  1: one-cycle pulse on a bit-stuff violation.

## Operation
Line state is decoded on every `shift_enable`:
- J = (1,0)
- K = (0,1)
- SE0 = (0,0)
- SE1 = (1,1), treated as SE0.

NRZI decode:
- Decoded bit = 1 if the line state equals the previous non-SE0 state, otherwise 0.
- The previous-state register updates only on J/K samples.

Bit unstuffing:
- `ones_cnt`, width $clog2(STUFF_LEN+1), counts consecutive decoded 1s.
- When `ones_cnt == STUFF_LEN`, the next J/K bit is the stuff bit. It is dropped: `bit_valid` stays 0 and `ones_cnt` clears.
- If that bit decodes as 1, it is a violation (see Configuration).
- A decoded 0 clears `ones_cnt`. A decoded 1 increments it, saturating at `STUFF_LEN`.

Deserialiser:
- Each valid bit shifts into bit `WORD_W-1` of a shift register (right shift).
- `bit_cnt` counts 0..`WORD_W-1`. On reaching `WORD_W-1` it wraps to 0 and loads `rx_word`.

EOP FSM states:
- `RX`: SE0 sample → `SE0_1`.
- `SE0_1`: SE0 → `SE0_2`; J/K → `RX`. The glitch is ignored and no bit is decoded for that sample.
- `SE0_2`: SE0 → stay; J → `EOP_J`; K → `RX` and `stuff_err` pulses.
- `EOP_J`: transient state. `eop` pulses, counters and `ones_cnt` clear, the partial word is discarded, the previous state is set to J, then → `RX`.

SE0 samples never produce `bit_valid`. `rcving` low forces `RX`, clears the counters and suppresses all pulses except `eop`.

## Timing
- Reset values:
  - `d_orig` = 1, `rx_word` = 0.
  - `bit_valid`, `word_valid`, `eop`, `stuff_err` = 0.
  - Previous state = J, `ones_cnt` = `bit_cnt` = 0, FSM = `RX`.
- Latency: every output is registered and updates in the cycle after the sampling `shift_enable`.
- `word_valid` coincides with the `bit_valid` of the word's last bit.
- `eop` asserts one cycle after the J sample that follows at least two SE0 samples.
- Simultaneous events:
  - Word completion and `stuff_err` in the same sample: both pulse.
  - `eop` never coincides with `word_valid`.
- Without `shift_enable`, all pulses are 0 and all state holds.
- Reset mid-packet: everything returns to reset values immediately (asynchronous); no pulse is emitted.

## Configuration
`USB_RX_STUFF_CHECK_EN`:
- Defined: a stuff bit decoding as 1 pulses `stuff_err`. That bit is still dropped, and it counts as the first of a new run of ones (`ones_cnt` = 1).
- Undefined: `stuff_err` is tied to 0 and the stuff bit is dropped unconditionally. The `SE0_2`→K case also does not flag.

## Structure
- Package `usb_rx_pkg`: line-state enum (`LS_J`, `LS_K`, `LS_SE0`) and EOP FSM state enum (`RX`, `SE0_1`, `SE0_2`, `EOP_J`).
- Sub-module `usb_line_state`: combinational D+/D- → line-state decode plus the previous-state register. Everything else lives in the top.

## Test plan
- Reset, then 8 J/K bits encoding 0x80 (the SYNC pattern KJKJKJKK) → `word_valid` pulses once, `rx_word` = 8'h80, `d_orig` sequence 0,0,0,0,0,0,0,1.
- Data 0xFF followed by 0x00 (encoder inserts one stuff 0 after six 1s) → exactly 16 `bit_valid` pulses, `rx_word` = 8'hFF then 8'h00, no `stuff_err`.
- Seven consecutive non-transitions with the macro defined → `stuff_err` pulses once, on the 7th sample. With the macro undefined → `stuff_err` stays 0.
- SE0, SE0, J after 3 data bits → `eop` pulses once, no `word_valid`, `bit_cnt` cleared. A following 8-bit packet decodes correctly.
- Single SE0 sample mid-packet → no `eop`, no `bit_valid` for that sample, word completes normally.
- `n_rst` asserted between bits 4 and 5 → all outputs return to reset values immediately. After release, the next packet decodes from bit 0.
